chirp_gen: RTL and testbench
============================

CHIRP_GEN -- requirements
Module: chirp_gen

Interface
REQ-001 Parameter WIDTH, default 8, bit width of period register and phase counter.
REQ-002 Parameter P_MIN, default 2, shortest half-period in clock cycles (1 <= P_MIN).
REQ-003 Parameter P_MAX, default 16, longest half-period in clock cycles (P_MIN <= P_MAX <= 2^WIDTH-1).
REQ-004 Parameter STEP, default 2, half-period change per full output cycle (STEP >= 1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 asyn_rst  input  1  synchronous, active-low reset, sampled on rising clk edge only.
REQ-007 start  input  1  level-sampled request to begin a sweep; honoured only in IDLE.
REQ-008 mode  input  1  0 = up sweep (P_MIN toward P_MAX), 1 = down sweep (P_MAX toward P_MIN); sampled with start only.
REQ-009 loop  input  1  1 = restart sweep automatically at end; sampled every cycle.
REQ-010 stop  input  1  abort request, highest functional priority.
REQ-011 out  output  1  chirp square wave.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse at natural end of non-looping sweep.
REQ-014 cur_period  output  WIDTH  half-period currently being generated; 0 in IDLE.

Function
REQ-015 Two states: IDLE, RUN; all outputs registered.
REQ-016 IDLE -> RUN on edge where start=1 and stop=0; same edge loads period = P_MIN (mode 0) or P_MAX (mode 1), latches mode, clears phase counter, sets out=1, busy=1.
REQ-017 In RUN, out holds each level for exactly period cycles, then toggles; one full output cycle = high phase then low phase.
REQ-018 Period updates only on edge ending a low phase: mode 0 next = min(period+STEP, P_MAX); mode 1 next = max(period-STEP, P_MIN); arithmetic in WIDTH+1 bits, no wrap-around.
REQ-019 Sweep end = completion of a full output cycle generated at end period (P_MAX in mode 0, P_MIN in mode 1).
REQ-020 At sweep end with loop=1: period reloads start value, out=1, stays RUN, no done pulse, no idle gap.
REQ-021 At sweep end with loop=0: -> IDLE, out=0, busy=0, cur_period=0, done=1 for exactly one cycle.
REQ-022 start while RUN ignored; mode changes while RUN ignored.
REQ-023 stop=1 in RUN: next edge -> IDLE, out=0, busy=0, cur_period=0, done stays 0.
REQ-024 stop and start both high in IDLE: remain IDLE.
REQ-025 stop coincident with sweep-end edge: stop wins, done stays 0.
REQ-026 P_MIN = P_MAX: sweep is a single full cycle of that half-period.
REQ-027 Final step clamps when (P_MAX-P_MIN) not multiple of STEP (e.g. 2,5,8,9 for P_MIN=2,P_MAX=9,STEP=3).

Reset
REQ-028 asyn_rst=0 at rising edge: state IDLE, out=0, busy=0, done=0, cur_period=0, phase counter 0, overriding all other inputs including mid-sweep.
REQ-029 Reset is not asynchronous: asserting asyn_rst between edges changes no output until next rising edge.
REQ-030 First start honoured on first edge with asyn_rst=1.

Verification
REQ-031 P_MIN=2,P_MAX=6,STEP=2,mode=0,loop=0, 1-cycle start pulse -> out high 2, low 2, high 4, low 4, high 6, low 6 (24 cycles), cur_period 2/4/6, done high one cycle immediately after, busy low.
REQ-032 Same params, mode=1 -> phases 6,6,4,4,2,2, done after 24 cycles.
REQ-033 loop=1, mode=0 -> after 24 cycles out returns high with cur_period=2, no done, busy stays 1; deassert loop mid-second-sweep -> done after that sweep.
REQ-034 stop asserted mid high phase of period 4 -> next edge out=0, busy=0, cur_period=0, no done; start again -> sweep restarts from P_MIN.
REQ-035 asyn_rst=0 for one cycle mid-sweep, also with start=1 -> all outputs zero after that edge; asyn_rst glitch between edges -> no change.
REQ-036 P_MIN=2,P_MAX=9,STEP=3 -> half-periods 2,5,8,9; start held high continuously with loop=0 -> new sweep begins the edge after done.

Source files
------------

// File: rtl/chirp_gen.sv
// chirp_gen: square-wave chirp generator.
// The half-period sweeps from P_MIN to P_MAX (mode 0) or from P_MAX to P_MIN
// (mode 1), changing by STEP once per full output cycle (high phase followed
// by low phase). The last step is clamped to the end value. At the end of a
// sweep the generator either restarts straight away (loop=1) or returns to
// IDLE with a one-cycle done pulse.
//
// Control handshake: start is a level request. It is accepted only in IDLE,
// on an edge where stop is low, and mode is captured on that same edge. While
// in RUN, start and mode are ignored. stop has priority over everything
// except reset. loop is sampled on the edge that ends a sweep.
//
// The FSM state is busy: busy is high exactly when the FSM is in RUN.
module chirp_gen #(
  parameter int WIDTH = 8,
  parameter int P_MIN = 2,
  parameter int P_MAX = 16,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             asyn_rst,
  input  logic             start,
  input  logic             mode,
  input  logic             loop,
  input  logic             stop,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cur_period
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Sweep limits at register width, and at one extra bit for the arithmetic
  // so that neither the sum nor the difference can wrap around.
  localparam logic [WIDTH-1:0] PMIN_W = WIDTH'(P_MIN);
  localparam logic [WIDTH-1:0] PMAX_W = WIDTH'(P_MAX);
  localparam logic [WIDTH:0]   PMIN_X = (WIDTH+1)'(P_MIN);
  localparam logic [WIDTH:0]   PMAX_X = (WIDTH+1)'(P_MAX);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_d;
  logic             out_d, busy_d, done_d;

  logic [WIDTH:0]   per_x;
  logic [WIDTH:0]   up_x;
  logic [WIDTH:0]   dn_x;
  logic [WIDTH-1:0] next_period;
  logic [WIDTH-1:0] start_period;
  logic [WIDTH-1:0] end_period;
  logic             phase_end;
  logic             sweep_end;

  // Next half-period and sweep end detection, derived from the latched mode.
  always_comb begin
    per_x        = {1'b0, cur_period};
    up_x         = per_x + STEP_X;
    dn_x         = per_x - STEP_X;
    start_period = mode_q ? PMAX_W : PMIN_W;
    end_period   = mode_q ? PMIN_W : PMAX_W;
    next_period  = cur_period;
    if (mode_q == 1'b0) begin
      // Clamp at P_MAX when the step would overshoot.
      if (up_x >= PMAX_X) next_period = PMAX_W;
      else                next_period = up_x[WIDTH-1:0];
    end else begin
      // Clamp at P_MIN; the comparison is done before subtracting.
      if (per_x < (PMIN_X + STEP_X)) next_period = PMIN_W;
      else                           next_period = dn_x[WIDTH-1:0];
    end
    // The current level has been held for cur_period cycles on this edge.
    phase_end = (({1'b0, cnt_q} + 1'b1) == per_x);
    // A full cycle at the end period finishes when its low phase ends.
    sweep_end = phase_end && !out && (cur_period == end_period);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    period_d = cur_period;
    out_d    = out;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        out_d    = 1'b0;
        busy_d   = 1'b0;
        period_d = '0;
        cnt_d    = '0;
        if (start && !stop) begin
          state_d  = RUN;
          mode_d   = mode;
          period_d = mode ? PMAX_W : PMIN_W;
          out_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort: no done pulse, even on a sweep-end edge.
          state_d  = IDLE;
          out_d    = 1'b0;
          busy_d   = 1'b0;
          period_d = '0;
          cnt_d    = '0;
        end else if (phase_end) begin
          cnt_d = '0;
          if (out) begin
            out_d = 1'b0;
          end else if (sweep_end) begin
            if (loop) begin
              // Restart with no idle gap; mode stays as latched.
              period_d = start_period;
              out_d    = 1'b1;
            end else begin
              state_d  = IDLE;
              out_d    = 1'b0;
              busy_d   = 1'b0;
              period_d = '0;
              done_d   = 1'b1;
            end
          end else begin
            // The period changes only at the end of a low phase.
            period_d = next_period;
            out_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        out_d    = 1'b0;
        busy_d   = 1'b0;
        period_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!asyn_rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      cur_period <= '0;
      out        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      cur_period <= period_d;
      out        <= out_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_chirp_gen.sv
// Testbench for chirp_gen: three instances with different sweep parameters
// driven by directed sequences and then random traffic, every output checked
// each cycle against a schedule-based reference model.
module tb_chirp_gen;

  localparam int N = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic asyn_rst = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus and outputs
  logic [N-1:0] start_v = '0;
  logic [N-1:0] mode_v  = '0;
  logic [N-1:0] loop_v  = '0;
  logic [N-1:0] stop_v  = '0;
  logic [N-1:0] out_v;
  logic [N-1:0] busy_v;
  logic [N-1:0] done_v;
  logic [7:0]   per_v [N];

  chirp_gen #(.WIDTH(8), .P_MIN(2), .P_MAX(6), .STEP(2)) dut_a (
    .clk(clk), .asyn_rst(asyn_rst), .start(start_v[0]), .mode(mode_v[0]),
    .loop(loop_v[0]), .stop(stop_v[0]), .out(out_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .cur_period(per_v[0]));

  chirp_gen #(.WIDTH(8), .P_MIN(2), .P_MAX(9), .STEP(3)) dut_b (
    .clk(clk), .asyn_rst(asyn_rst), .start(start_v[1]), .mode(mode_v[1]),
    .loop(loop_v[1]), .stop(stop_v[1]), .out(out_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .cur_period(per_v[1]));

  chirp_gen #(.WIDTH(8), .P_MIN(5), .P_MAX(5), .STEP(1)) dut_c (
    .clk(clk), .asyn_rst(asyn_rst), .start(start_v[2]), .mode(mode_v[2]),
    .loop(loop_v[2]), .stop(stop_v[2]), .out(out_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .cur_period(per_v[2]));

  // Scoreboard counters and the checking task
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a sweep is expanded into a per-cycle schedule of
  // {out, half-period} entries; the model walks through it one entry per edge.
  int pmn [N] = '{2, 2, 5};
  int pmx [N] = '{6, 9, 5};
  int stp [N] = '{2, 3, 1};

  logic [8:0] sched [N][64];
  int         slen  [N];
  int         spos  [N];
  bit         m_run [N];
  logic       m_out [N];
  logic       m_busy[N];
  logic       m_done[N];
  logic [7:0] m_per [N];

  task automatic build(input int i, input bit md);
    int p, n, last;
    p    = md ? pmx[i] : pmn[i];
    last = md ? pmn[i] : pmx[i];
    n    = 0;
    while (1) begin
      for (int k = 0; k < p; k++) begin sched[i][n] = {1'b1, p[7:0]}; n++; end
      for (int k = 0; k < p; k++) begin sched[i][n] = {1'b0, p[7:0]}; n++; end
      if (p == last) break;
      if (md) p = (p - stp[i] < pmn[i]) ? pmn[i] : p - stp[i];
      else    p = (p + stp[i] > pmx[i]) ? pmx[i] : p + stp[i];
    end
    slen[i] = n;
    spos[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_out[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_per[i] = '0;
      slen[i] = 0; spos[i] = 0;
    end
  end

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_out%0d", tag, i),  32'(out_v[i]),  32'(m_out[i]));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 32'(m_busy[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 32'(m_done[i]));
      check($sformatf("%s_per%0d", tag, i),  32'(per_v[i]),  32'(m_per[i]));
    end
  endtask

  // Advance the model on each rising edge, then compare just after it.
  bit checking = 1'b1;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      m_done[i] = 1'b0;
      if (!asyn_rst) begin
        m_run[i] = 0;
      end else if (m_run[i]) begin
        if (stop_v[i]) m_run[i] = 0;
        else begin
          spos[i]++;
          if (spos[i] == slen[i]) begin
            if (loop_v[i]) spos[i] = 0;
            else begin m_run[i] = 0; m_done[i] = 1'b1; end
          end
        end
      end else if (start_v[i] && !stop_v[i]) begin
        build(i, mode_v[i]);
        m_run[i] = 1;
      end
      if (m_run[i]) begin
        {m_out[i], m_per[i]} = sched[i][spos[i]];
        m_busy[i] = 1'b1;
      end else begin
        m_out[i] = 1'b0; m_per[i] = '0; m_busy[i] = 1'b0;
      end
    end
    #1;
    if (checking) compare_all("cyc");
  end

  // Driver tasks: inputs change only on falling edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i, input bit md, input bit lp);
    mode_v[i] = md; loop_v[i] = lp; start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  // Reset glitch between edges must not disturb any output.
  task automatic rst_glitch();
    #2 asyn_rst = 1'b0;
    #1 compare_all("glitch");
    asyn_rst = 1'b1;
  endtask

  initial begin
    // Reset, with start requested during reset to prove it is overridden.
    start_v = '1;
    tick(3);
    start_v = '0;
    asyn_rst = 1'b1;
    tick(2);

    // Up and down sweeps, no loop; instance c is the single-cycle sweep.
    pulse_start(0, 1'b0, 1'b0);
    tick(4); rst_glitch();
    tick(30);
    pulse_start(0, 1'b1, 1'b0);
    pulse_start(2, 1'b0, 1'b0);
    tick(30);

    // Looping up sweep; loop dropped partway through the second sweep.
    pulse_start(0, 1'b0, 1'b1);
    mode_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick(34);
    start_v[0] = 1'b0;
    loop_v[0] = 1'b0;
    tick(30);

    // Stop in the middle of the period-4 high phase, then restart.
    pulse_start(0, 1'b0, 1'b0);
    tick(4);
    stop_v[0] = 1'b1; tick(1); stop_v[0] = 1'b0;
    tick(3);
    pulse_start(0, 1'b0, 1'b0);
    tick(10);

    // Reset mid-sweep with start held high.
    start_v[0] = 1'b1;
    asyn_rst = 1'b0; tick(1); asyn_rst = 1'b1;
    start_v[0] = 1'b0;
    tick(30);

    // Clamped sweep 2,5,8,9 with start held continuously; also stop+start in IDLE.
    start_v[1] = 1'b1; stop_v[1] = 1'b1; tick(2); stop_v[1] = 1'b0;
    tick(110);
    start_v[1] = 1'b0;
    tick(50);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        start_v[i] = ($urandom_range(0, 7) == 0);
        mode_v[i]  = 1'($urandom_range(0, 1));
        loop_v[i]  = ($urandom_range(0, 3) != 0) ? loop_v[i] : 1'($urandom_range(0, 1));
        stop_v[i]  = ($urandom_range(0, 59) == 0);
      end
      asyn_rst = ($urandom_range(0, 249) != 0);
      tick(1);
      if ($urandom_range(0, 99) == 0 && asyn_rst) rst_glitch();
    end

    checking = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
